// File: rtl/llr_frame_loader_if.sv
// rtl/llr_frame_loader_if.sv - sample-in / frame-out handshake bundle for llr_frame_loader
interface llr_frame_loader_if #(
  parameter int SIZE  = 20,
  parameter int IN_W  = 24,
  parameter int N     = 8,
  parameter int LOG_N = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_llr;
  logic                frm_valid;
  logic                frm_ready;
  logic [N*SIZE-1:0]   frm_llr;
  logic [LOG_N:0]      frm_sat_cnt;

  modport master (
    output in_valid, in_llr, frm_ready,
    input  in_ready, frm_valid, frm_llr, frm_sat_cnt
  );

  modport slave (
    input  in_valid, in_llr, frm_ready,
    output in_ready, frm_valid, frm_llr, frm_sat_cnt
  );
endinterface

// File: rtl/llr_frame_loader.sv
// rtl/llr_frame_loader.sv - saturating ping-pong LLR frame packer; LLR_SAT_CNT_EN adds per-frame clamp count
module llr_frame_loader #(
  parameter int SIZE  = 20,
  parameter int IN_W  = 24,
  parameter int N     = 8,
  parameter int LOG_N = 3
) (
  input logic               clk,
  input logic               rst,
  llr_frame_loader_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_t;

  bank_t             bank_st [2];
  bank_t             bank_nx [2];
  logic              wr_bank, wr_bank_nx;
  logic              rd_bank, rd_bank_nx;
  logic [LOG_N-1:0]  wr_idx, wr_idx_nx;
  logic [SIZE-1:0]   mem [2][N];

  logic              accept;
  logic              take;
  logic [IN_W-SIZE:0] hi;
  logic              in_range;
  logic [SIZE-1:0]   sat_llr;

  // Sample fits when all bits from the SIZE sign bit upward agree.
  assign hi       = bus.in_llr[IN_W-1:SIZE-1];
  assign in_range = (&hi) | ~(|hi);

  always_comb begin
    sat_llr = bus.in_llr[SIZE-1:0];
    if (!in_range)
      sat_llr = hi[IN_W-SIZE] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
  end

  assign bus.in_ready  = (bank_st[wr_bank] != FULL);
  assign bus.frm_valid = (bank_st[rd_bank] == FULL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign take          = bus.frm_valid && bus.frm_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= '0;
    end else begin
      bank_st[0] <= bank_nx[0];
      bank_st[1] <= bank_nx[1];
      wr_bank    <= wr_bank_nx;
      rd_bank    <= rd_bank_nx;
      wr_idx     <= wr_idx_nx;
    end
  end

  // Read and write sides always target different banks when both fire.
  always_comb begin
    bank_nx[0] = bank_st[0];
    bank_nx[1] = bank_st[1];
    wr_bank_nx = wr_bank;
    rd_bank_nx = rd_bank;
    wr_idx_nx  = wr_idx;
    if (take) begin
      bank_nx[rd_bank] = EMPTY;
      rd_bank_nx       = ~rd_bank;
    end
    if (accept) begin
      if (wr_idx == LOG_N'(N-1)) begin
        bank_nx[wr_bank] = FULL;
        wr_idx_nx        = '0;
        wr_bank_nx       = ~wr_bank;
      end else begin
        bank_nx[wr_bank] = FILLING;
        wr_idx_nx        = wr_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++)
          mem[b][i] <= '0;
    end else if (accept) begin
      mem[wr_bank][wr_idx] <= sat_llr;
    end
  end

  always_comb begin
    bus.frm_llr = '0;
    for (int i = 0; i < N; i++)
      bus.frm_llr[i*SIZE +: SIZE] = mem[rd_bank][i];
  end

`ifdef LLR_SAT_CNT_EN
  logic [LOG_N:0] sat_cnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt[0] <= '0;
      sat_cnt[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (take && rd_bank == 1'(b))
          sat_cnt[b] <= '0;
        else if (accept && !in_range && wr_bank == 1'(b))
          sat_cnt[b] <= sat_cnt[b] + 1'b1;
      end
    end
  end

  assign bus.frm_sat_cnt = sat_cnt[rd_bank];
`else
  assign bus.frm_sat_cnt = '0;
`endif

endmodule
